bcd_uart_formatter: RTL and testbench

Converts one converted stopwatch reading (four BCD digits) into an ASCII text frame and writes it byte-by-byte into the UART transmit FIFO. It sits directly downstream of the binary-to-BCD converter: that converter's `done_tick` drives `start`, and its four digit outputs drive `bcd3..bcd0`. Its output pair `wr_uart`/`w_data` drives the UART TX FIFO write port, with backpressure taken from the FIFO's `tx_full`.

---
 rtl/bcd_uart_formatter.sv | 131 +++++++++++++
 tb/tb_bcd_uart_formatter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_uart_formatter.sv
// Formats four BCD digits into an ASCII frame and writes it byte by byte into the UART TX FIFO.
// Latency: first byte 1 cycle after start, then one byte per cycle. Backpressure: tx_full holds the current byte, nothing is dropped.
module bcd_uart_formatter #(
    parameter int DP_POS     = 1,
    parameter int LEAD_BLANK = 1,
    parameter int EOL        = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       ready,
    output logic       done_tick
);

    localparam int HAS_DP = (DP_POS != 0) ? 1 : 0;
    // Digit slot (0 = most significant) sitting immediately left of the point.
    localparam int DP_K   = 3 - DP_POS;
    localparam int NDIG   = 4 + HAS_DP;
    localparam int N      = NDIG + 2 * ((EOL != 0) ? 1 : 0);
    localparam logic [2:0] LAST = 3'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] idx_q;
    logic [2:0] idx_d;
    logic       latch;
    logic [3:0] dig [4];
    logic [7:0] dig_char [4];
    logic [7:0] frame [8];
    logic       zero_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                dig[k] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (latch) begin
                dig[0] <= bcd3;
                dig[1] <= bcd2;
                dig[2] <= bcd1;
                dig[3] <= bcd0;
            end
        end
    end

    // A digit blanks only while it and everything more significant are zero.
    always_comb begin
        zero_run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            zero_run = zero_run & (dig[k] == 4'd0);
            if ((LEAD_BLANK != 0) && (k < DP_K) && zero_run) begin
                dig_char[k] = 8'h20;
            end else if (dig[k] <= 4'd9) begin
                dig_char[k] = {4'h3, dig[k]};
            end else begin
                dig_char[k] = 8'h3F;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            frame[i] = 8'h00;
        end
        for (int k = 0; k < 4; k++) begin
            frame[k + (((HAS_DP != 0) && (k > DP_K)) ? 1 : 0)] = dig_char[k];
        end
        if (HAS_DP != 0) begin
            frame[DP_K + 1] = 8'h2E;
        end
        if (EOL != 0) begin
            frame[NDIG]     = 8'h0D;
            frame[NDIG + 1] = 8'h0A;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        latch     = 1'b0;
        ready     = 1'b0;
        wr_uart   = 1'b0;
        w_data    = 8'h00;
        done_tick = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    latch   = 1'b1;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                w_data  = frame[idx_q];
                wr_uart = !tx_full;
                if (!tx_full) begin
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE: begin
                done_tick = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bcd_uart_formatter.sv
// Bench for bcd_uart_formatter: three parameterisations driven from directed and random frames.
module tb_bcd_uart_formatter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic [3:0] bcd3 = 4'd0, bcd2 = 4'd0, bcd1 = 4'd0, bcd0 = 4'd0;
    logic       tx_full = 1'b0;
    logic [2:0] wr_v, rdy_v, done_v;
    logic [7:0] wd_v [3];

    int checks = 0;
    int errors = 0;

    // Instance configurations: {DP_POS, LEAD_BLANK, EOL}
    localparam int DPP [3] = '{1, 0, 1};
    localparam int LBP [3] = '{1, 1, 0};
    localparam int EOP [3] = '{1, 0, 1};

    always #5 clk = ~clk;

    bcd_uart_formatter #(.DP_POS(1), .LEAD_BLANK(1), .EOL(1)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .tx_full(tx_full),
        .wr_uart(wr_v[0]), .w_data(wd_v[0]), .ready(rdy_v[0]), .done_tick(done_v[0])
    );

    bcd_uart_formatter #(.DP_POS(0), .LEAD_BLANK(1), .EOL(0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .tx_full(tx_full),
        .wr_uart(wr_v[1]), .w_data(wd_v[1]), .ready(rdy_v[1]), .done_tick(done_v[1])
    );

    bcd_uart_formatter #(.DP_POS(1), .LEAD_BLANK(0), .EOL(1)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .tx_full(tx_full),
        .wr_uart(wr_v[2]), .w_data(wd_v[2]), .ready(rdy_v[2]), .done_tick(done_v[2])
    );

    // Reference: builds the frame text as a left-aligned byte string.
    function automatic logic [55:0] model(input int dp, input int lb, input int eol,
                                          input logic [3:0] d3, input logic [3:0] d2,
                                          input logic [3:0] d1, input logic [3:0] d0,
                                          output int n);
        logic [3:0]  d [4];
        logic [55:0] v;
        int          pos;
        int          left;
        bit          all_zero;
        logic [7:0]  ch;
        d[0] = d3; d[1] = d2; d[2] = d1; d[3] = d0;
        v = '0;
        pos = 0;
        left = 4 - dp;
        all_zero = 1'b1;
        for (int k = 0; k < 4; k++) begin
            all_zero = all_zero && (d[k] == 4'd0);
            if (lb != 0 && k < left - 1 && all_zero) ch = 8'h20;
            else if (d[k] <= 4'd9) ch = 8'h30 + {4'h0, d[k]};
            else ch = 8'h3F;
            v[55 - 8*pos -: 8] = ch;
            pos++;
            if (dp != 0 && k == left - 1) begin
                v[55 - 8*pos -: 8] = 8'h2E;
                pos++;
            end
        end
        if (eol != 0) begin
            v[55 - 8*pos -: 8] = 8'h0D;
            v[55 - 8*(pos+1) -: 8] = 8'h0A;
            pos += 2;
        end
        n = pos;
        return v;
    endfunction

    function automatic logic [3:0] rnd_digit();
        int r;
        r = $urandom % 10;
        if (r < 4) return 4'd0;
        else if (r < 8) return 4'($urandom_range(1, 9));
        else return 4'($urandom_range(10, 15));
    endfunction

    // Runs one frame on instance inst; expv holds the n expected bytes left-aligned.
    // stall_at/stall_len: hold tx_full after stall_at bytes; pct: random tx_full percentage;
    // stale_cyc: cycle in which a second start and new digits are presented.
    task automatic run_frame(input int inst, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d,
                             input logic [55:0] expv, input int n,
                             input int stall_at, input int stall_len, input int pct,
                             input int stale_cyc, input string name);
        int idx, cyc, stalls, stall_rem, done_cyc;
        bit finished;
        logic [7:0] exp_b;
        idx = 0; cyc = 1; stalls = 0; stall_rem = stall_len; done_cyc = -1; finished = 1'b0;
        @(posedge clk); #1;
        bcd3 = a; bcd2 = b; bcd1 = c; bcd0 = d;
        tx_full = 1'b0;
        start_v[inst] = 1'b1;
        @(posedge clk); #1;
        start_v[inst] = 1'b0;
        while (!finished && cyc < 60) begin
            start_v[inst] = (cyc == stale_cyc);
            if (cyc == stale_cyc) begin
                bcd3 = 4'd9; bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9;
            end
            if (idx < n && idx == stall_at && stall_rem > 0) begin
                tx_full = 1'b1;
                stall_rem--;
            end else begin
                tx_full = (pct > 0) ? (($urandom % 100) < pct) : 1'b0;
            end
            @(negedge clk);
            if (idx < n) begin
                exp_b = expv[55 - 8*idx -: 8];
                if (wr_v[inst] !== !tx_full) begin
                    errors++;
                    $display("FAIL %s wr_uart cyc %0d got %b want %b", name, cyc, wr_v[inst], !tx_full);
                end
                checks++;
                if (wd_v[inst] !== exp_b) begin
                    errors++;
                    $display("FAIL %s w_data byte %0d cyc %0d got %h want %h", name, idx, cyc, wd_v[inst], exp_b);
                end
                checks++;
                if (rdy_v[inst] !== 1'b0 || done_v[inst] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy flags cyc %0d got ready=%b done=%b want 0 0", name, cyc, rdy_v[inst], done_v[inst]);
                end
                checks++;
                if (!tx_full) idx++;
                else stalls++;
            end else if (done_cyc < 0) begin
                if (done_v[inst] !== 1'b1 || cyc != n + 1 + stalls) begin
                    errors++;
                    $display("FAIL %s done_tick cyc %0d got %b want 1 at cyc %0d", name, cyc, done_v[inst], n + 1 + stalls);
                end
                checks++;
                if (wr_v[inst] !== 1'b0 || wd_v[inst] !== 8'h00) begin
                    errors++;
                    $display("FAIL %s done outputs got wr=%b data=%h want 0 00", name, wr_v[inst], wd_v[inst]);
                end
                checks++;
                done_cyc = cyc;
            end else begin
                if (rdy_v[inst] !== 1'b1 || done_v[inst] !== 1'b0 || wr_v[inst] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s return to idle cyc %0d got ready=%b done=%b wr=%b want 1 0 0", name, cyc, rdy_v[inst], done_v[inst], wr_v[inst]);
                end
                checks++;
                finished = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_v[inst] = 1'b0;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout got %0d bytes want %0d", name, idx, n);
        end
        checks++;
        tx_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rdy_v[inst] !== 1'b1 || done_v[inst] !== 1'b0 || wr_v[inst] !== 1'b0) begin
                errors++;
                $display("FAIL %s idle tail got ready=%b done=%b wr=%b want 1 0 0", name, rdy_v[inst], done_v[inst], wr_v[inst]);
            end
            checks++;
        end
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            if (rdy_v[i] !== 1'b1 || wr_v[i] !== 1'b0 || done_v[i] !== 1'b0 || wd_v[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset inst %0d got ready=%b wr=%b done=%b data=%h want 1 0 0 00", i, rdy_v[i], wr_v[i], done_v[i], wd_v[i]);
            end
            checks++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        if (rdy_v[0] !== 1'b1 || wr_v[0] !== 1'b0 || wd_v[0] !== 8'h00) begin
            errors++;
            $display("FAIL post_reset got ready=%b wr=%b data=%h want 1 0 00", rdy_v[0], wr_v[0], wd_v[0]);
        end
        checks++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_b [4];
        exp_b = '{8'h31, 8'h32, 8'h33, 8'h2E};
        @(posedge clk); #1;
        bcd3 = 4'd1; bcd2 = 4'd2; bcd1 = 4'd3; bcd0 = 4'd4;
        tx_full = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wr_v[0] !== 1'b1 || wd_v[0] !== exp_b[i]) begin
                errors++;
                $display("FAIL reset_mid byte %0d got wr=%b data=%h want 1 %h", i, wr_v[0], wd_v[0], exp_b[i]);
            end
            checks++;
            @(posedge clk); #1;
        end
        #1;
        if (wr_v[0] !== 1'b1 || wd_v[0] !== exp_b[3]) begin
            errors++;
            $display("FAIL reset_mid byte 3 got wr=%b data=%h want 1 %h", wr_v[0], wd_v[0], exp_b[3]);
        end
        checks++;
        reset = 1'b1;
        #1;
        if (wr_v[0] !== 1'b0 || rdy_v[0] !== 1'b1 || wd_v[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid async drop got wr=%b ready=%b data=%h want 0 1 00", wr_v[0], rdy_v[0], wd_v[0]);
        end
        checks++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0 || wr_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid abandoned got done=%b wr=%b ready=%b want 0 0 1", done_v[0], wr_v[0], rdy_v[0]);
            end
            checks++;
        end
        run_frame(0, 4'd5, 4'd6, 4'd7, 4'd8, 56'h3536372E380D0A, 7, -1, 0, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [3:0]  d [4];
        logic [55:0] expv;
        int          n;
        int          inst;
        for (int t = 0; t < 30; t++) begin
            inst = $urandom % 3;
            for (int k = 0; k < 4; k++) d[k] = rnd_digit();
            expv = model(DPP[inst], LBP[inst], EOP[inst], d[0], d[1], d[2], d[3], n);
            run_frame(inst, d[0], d[1], d[2], d[3], expv, n, -1, 0, 35, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        run_frame(0, 4'd1, 4'd2, 4'd3, 4'd4, 56'h3132332E340D0A, 7, -1, 0, 0, 0, "basic");
        run_frame(0, 4'd0, 4'd0, 4'd0, 4'd5, 56'h2020302E350D0A, 7, -1, 0, 0, 0, "blank_0005");
        run_frame(0, 4'd0, 4'd1, 4'd0, 4'd0, 56'h2031302E300D0A, 7, -1, 0, 0, 0, "blank_0100");
        run_frame(0, 4'd1, 4'd2, 4'd3, 4'd4, 56'h3132332E340D0A, 7, 2, 3, 0, 0, "backpressure");
        run_frame(0, 4'd1, 4'd2, 4'd3, 4'd4, 56'h3132332E340D0A, 7, -1, 0, 0, 3, "stale_start");
        run_frame(1, 4'hA, 4'd0, 4'd0, 4'd7, 56'h3F303037000000, 4, -1, 0, 0, 0, "dp0_noeol");
        run_frame(2, 4'd0, 4'd0, 4'd0, 4'd0, 56'h3030302E300D0A, 7, -1, 0, 0, 0, "no_blank");
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
